// File: rtl/cla_prefix_adder_pipe.sv
// Pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready flow
// control and a sideband tag. Stage 0 registers the bit-level (g,p) pairs.
// Each following stage resolves REG_EVERY prefix levels. The last stage also
// forms the carries and registers sum/cout/ovf/group outputs directly.
module cla_prefix_adder_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 2,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             grp_g,
    output logic             grp_p,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned L  = $clog2(WIDTH);
    localparam int unsigned NS = (L + REG_EVERY - 1) / REG_EVERY;

    // Global advance: every stage shifts together whenever the output slot frees up
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Operand conditioning for subtraction (a + ~b + 1)
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
    assign b_eff = sub ? ~b : b;
    assign c0_in = sub | cin;

    // Per-stage pipeline state; index 0 is the input register
    logic             st_v   [NS];
    logic [WIDTH-1:0] st_g   [NS];
    logic [WIDTH-1:0] st_p   [NS];
    logic [WIDTH-1:0] st_pb  [NS];
    logic             st_c0  [NS];
    logic [TAG_W-1:0] st_tag [NS];

    // Group (G,P) after the prefix levels owned by each stage
    logic [WIDTH-1:0] lvl_g [NS];
    logic [WIDTH-1:0] lvl_p [NS];

    // Prefix levels: stage j resolves levels j*REG_EVERY .. (j+1)*REG_EVERY-1
    always_comb begin
        for (int j = 0; j < int'(NS); j++) begin : stage_levels
            logic [WIDTH-1:0] gc;
            logic [WIDTH-1:0] pc;
            gc = st_g[j];
            pc = st_p[j];
            for (int k = 0; k < int'(L); k++) begin
                if ((k / int'(REG_EVERY)) == j) begin
                    // Bits below the span pass through unchanged
                    gc = gc | (pc & (gc << (1 << k)));
                    pc = pc & ((pc << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
                end
            end
            lvl_g[j] = gc;
            lvl_p[j] = pc;
        end
    end

    // Carries from the fully resolved prefix: c_{i+1} = G[i:0] | (P[i:0] & c0)
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] res_sum;
    assign carry   = {lvl_g[NS-1] | (lvl_p[NS-1] & {WIDTH{st_c0[NS-1]}}), st_c0[NS-1]};
    assign res_sum = st_pb[NS-1] ^ carry[WIDTH-1:0];

    // Pipeline stage registers; bubbles shift with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < int'(NS); j++) begin
                st_v[j]   <= 1'b0;
                st_g[j]   <= '0;
                st_p[j]   <= '0;
                st_pb[j]  <= '0;
                st_c0[j]  <= 1'b0;
                st_tag[j] <= '0;
            end
        end else if (adv) begin
            st_v[0]   <= in_valid;
            st_g[0]   <= a & b_eff;
            st_p[0]   <= a ^ b_eff;
            st_pb[0]  <= a ^ b_eff;
            st_c0[0]  <= c0_in;
            st_tag[0] <= tag_in;
            for (int j = 1; j < int'(NS); j++) begin
                st_v[j]   <= st_v[j-1];
                st_g[j]   <= lvl_g[j-1];
                st_p[j]   <= lvl_p[j-1];
                st_pb[j]  <= st_pb[j-1];
                st_c0[j]  <= st_c0[j-1];
                st_tag[j] <= st_tag[j-1];
            end
        end
    end

    // Output register: final carry resolution and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            grp_g     <= 1'b0;
            grp_p     <= 1'b0;
            tag_out   <= '0;
        end else if (adv) begin
            out_valid <= st_v[NS-1];
            sum       <= res_sum;
            cout      <= carry[WIDTH];
            ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
            grp_g     <= lvl_g[NS-1][WIDTH-1];
            grp_p     <= lvl_p[NS-1][WIDTH-1];
            tag_out   <= st_tag[NS-1];
        end
    end

endmodule

// File: tb/tb_cla_prefix_adder_pipe.sv
// Directed and randomized checks for the pipelined prefix adder (default params).
module tb_cla_prefix_adder_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        grp_g;
    logic        grp_p;
    logic [3:0]  tag_out;

    int checks = 0;
    int errors = 0;

    cla_prefix_adder_pipe #(.WIDTH(32), .REG_EVERY(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf),
        .grp_g(grp_g), .grp_p(grp_p), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {sum, cout, ovf, grp_g, grp_p, tag} from plain integer arithmetic
    function automatic logic [39:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub,
                                          input logic [3:0] mtag);
        logic [31:0] be;
        logic        c0;
        logic [32:0] full;
        logic [32:0] nocarry;
        logic        v;
        be      = msub ? ~mb : mb;
        c0      = msub ? 1'b1 : mcin;
        full    = {1'b0, ma} + {1'b0, be} + 33'(c0);
        nocarry = {1'b0, ma} + {1'b0, be};
        v       = (ma[31] == be[31]) && (full[31] != ma[31]);
        return {full[31:0], full[32], v, nocarry[32], &(ma ^ be), mtag};
    endfunction

    // Present one op, then count edges (accept edge = 1) until out_valid
    task automatic send_and_wait(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic icin, input logic isub,
                                 input logic [3:0] itag, output int lat);
        a = ia; b = ib; cin = icin; sub = isub; tag_in = itag;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag_in = '0;
        tick;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || tag_out !== 4'h0 || cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values got valid=%b sum=%h tag=%h cout=%b rdy=%b exp 0/0/0/0/1",
                     out_valid, sum, tag_out, cout, in_ready);
        end
        rst = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 32'(i + 1); b = 32'h1; tag_in = 4'(i);
            tick;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h3) begin
            errors++;
            $display("FAIL pre_reset_stream got valid=%b sum=%h exp 1/00000003", out_valid, sum);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || tag_out !== 4'h0) begin
            errors++;
            $display("FAIL async_reset got valid=%b sum=%h tag=%h exp 0/0/0", out_valid, sum, tag_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_reset got %b exp 1", in_ready);
        end
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush got stale_valid=%b exp 0", seen);
        end
    endtask

    task automatic test_add;
        int lat;
        send_and_wait(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd5, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_latency got %0d exp 4", lat);
        end
        checks++;
        if ({sum, cout, ovf, grp_g, grp_p, tag_out} !== {32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5}) begin
            errors++;
            $display("FAIL add_wrap got sum=%h c=%b v=%b G=%b P=%b tag=%h exp 00000000 1 0 1 0 5",
                     sum, cout, ovf, grp_g, grp_p, tag_out);
        end
        tick;
        // Carry-in rippling through an all-propagate word
        send_and_wait(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd9, lat);
        checks++;
        if ({sum, cout, ovf, grp_g, grp_p, tag_out} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9}) begin
            errors++;
            $display("FAIL add_cin_prop got sum=%h c=%b v=%b G=%b P=%b tag=%h exp 00000000 1 0 0 1 9",
                     sum, cout, ovf, grp_g, grp_p, tag_out);
        end
        tick;
    endtask

    task automatic test_overflow;
        int lat;
        send_and_wait(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3, lat);
        checks++;
        if ({sum, cout, ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL signed_ovf got sum=%h c=%b v=%b exp 80000000 0 1", sum, cout, ovf);
        end
        tick;
        send_and_wait(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'd4, lat);
        checks++;
        if ({sum, cout, ovf} !== {32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL neg_ovf got sum=%h c=%b v=%b exp 00000000 1 1", sum, cout, ovf);
        end
        tick;
    endtask

    task automatic test_sub;
        int lat;
        send_and_wait(32'd10, 32'd3, 1'b1, 1'b1, 4'd1, lat);
        checks++;
        if ({sum, cout, ovf, grp_g, grp_p} !== {32'd7, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_pos got sum=%h c=%b v=%b G=%b P=%b exp 00000007 1 0 1 0",
                     sum, cout, ovf, grp_g, grp_p);
        end
        tick;
        send_and_wait(32'd3, 32'd10, 1'b0, 1'b1, 4'd2, lat);
        checks++;
        if ({sum, cout, ovf} !== {32'hFFFF_FFF9, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_neg got sum=%h c=%b v=%b exp fffffff9 0 0", sum, cout, ovf);
        end
        tick;
        send_and_wait(32'd10, 32'd3, 1'b0, 1'b1, 4'd6, lat);
        checks++;
        if (sum !== 32'd7 || cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_ignores_cin got sum=%h c=%b exp 00000007 1", sum, cout);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got = 0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_sum;
        logic [3:0]  prev_tag;
        logic [35:0] q[$];
        logic [35:0] exp_v;
        cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            out_ready = !(c >= 6 && c <= 10);
            if (sent < 8) begin
                in_valid = 1'b1; a = 32'h100 + 32'(sent); b = 32'(sent * 3); tag_in = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (!out_valid || sum !== prev_sum || tag_out !== prev_tag) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b sum=%h tag=%h exp 1 %h %h",
                             out_valid, sum, tag_out, prev_sum, prev_tag);
                end
            end
            prev_stall = 1'b0;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready got %b exp 0", in_ready);
                end
                prev_stall = 1'b1; prev_sum = sum; prev_tag = tag_out;
            end else if (out_valid && out_ready) begin
                checks++;
                exp_v = (q.size() > 0) ? q.pop_front() : 36'hF_FFFF_FFFF;
                if ({sum, tag_out} !== exp_v) begin
                    errors++;
                    $display("FAIL bp_result got sum=%h tag=%h exp %h %h", sum, tag_out,
                             exp_v[35:4], exp_v[3:0]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back({32'h100 + 32'(sent) + 32'(sent * 3), 4'(sent)});
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== 8 || q.size() !== 0) begin
            errors++;
            $display("FAIL bp_count got %0d results (%0d pending) exp 8 (0)", got, q.size());
        end
        tick;
    endtask

    task automatic test_random;
        logic [39:0] q[$];
        logic [39:0] exp_v;
        int sent = 0;
        int got = 0;
        int n = 300;
        bit acc;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 6000 && got < n; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                a = $urandom; b = $urandom;
                if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
                if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
                if ($urandom_range(0, 9) == 0) b = ~a;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                tag_in = 4'($urandom_range(0, 15));
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                exp_v = (q.size() > 0) ? q.pop_front() : 40'hFF_FFFF_FFFF;
                if ({sum, cout, ovf, grp_g, grp_p, tag_out} !== exp_v) begin
                    errors++;
                    $display("FAIL rand_result got %h exp %h",
                             {sum, cout, ovf, grp_g, grp_p, tag_out}, exp_v);
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(a, b, cin, sub, tag_in));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== n) begin
            errors++;
            $display("FAIL rand_count got %0d exp %0d", got, n);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_overflow;
        test_sub;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
